// File: rtl/int2flt_pkg.sv
// Shared types and helpers for the sequential integer-to-float converter.
package int2flt_pkg;

    // Rounding direction selected per operand.
    typedef enum logic [1:0] {
        RNE = 2'd0,
        RTZ = 2'd1,
        RUP = 2'd2,
        RDN = 2'd3
    } rnd_mode_t;

    // Converter control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Exponent bias for an exponent field of the given width.
    function automatic int bias(input int exp_w);
        return (32'sd1 <<< (exp_w - 32'sd1)) - 32'sd1;
    endfunction

endpackage

// File: rtl/int2flt_seq_round.sv
// Rounding stage: turns a normalized magnitude into exponent, mantissa and flags.
module flt_round
    import int2flt_pkg::*;
#(
    parameter int MAG_W = 16,
    parameter int LZ_W  = 4,
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
)(
    input  logic [MAG_W-2:0] frac,     // bits below the normalized (hidden) one
    input  logic [LZ_W-1:0]  lz,
    input  logic             sign,
    input  rnd_mode_t        mode,
    output logic [EXP_W-1:0] exp,
    output logic [MAN_W-1:0] mant,
    output logic             inexact,
    output logic             ovf
);

    // Fraction is padded with zeros so guard/sticky fall out naturally when the
    // mantissa field is at least as wide as the fraction.
    localparam int EXT_W   = MAG_W + MAN_W;
    localparam int BIAS_V  = bias(EXP_W);
    localparam int EXP_MAX = (32'sd1 <<< EXP_W) - 32'sd1;

    logic [EXT_W-1:0] ext_s;
    logic [MAN_W-1:0] mant_raw_s;
    logic             guard_s;
    logic             sticky_s;
    logic             inc_s;
    logic [MAN_W:0]   mant_sum_s;
    logic [31:0]      e_s;
    logic             ovf_s;
    logic             inf_s;

    // Extract mantissa/guard/sticky, apply the rounding increment and saturate.
    always_comb begin
        ext_s      = {frac, {(MAN_W+1){1'b0}}};
        mant_raw_s = ext_s[EXT_W-1 -: MAN_W];
        guard_s    = ext_s[EXT_W-1-MAN_W];
        sticky_s   = |ext_s[EXT_W-2-MAN_W:0];

        case (mode)
            RNE:     inc_s = guard_s & (sticky_s | mant_raw_s[0]);
            RTZ:     inc_s = 1'b0;
            RUP:     inc_s = (guard_s | sticky_s) & ~sign;
            RDN:     inc_s = (guard_s | sticky_s) & sign;
            default: inc_s = 1'b0;
        endcase

        mant_sum_s = {1'b0, mant_raw_s} + {{MAN_W{1'b0}}, inc_s};

        // A mantissa carry-out leaves the low bits at zero and bumps the exponent.
        e_s = 32'(BIAS_V) + 32'(MAG_W - 1) - 32'(lz)
              + (mant_sum_s[MAN_W] ? 32'd1 : 32'd0);
        ovf_s = (e_s >= 32'(EXP_MAX));

        case (mode)
            RNE:     inf_s = 1'b1;
            RUP:     inf_s = ~sign;
            RDN:     inf_s = sign;
            default: inf_s = 1'b0;
        endcase

        if (ovf_s) begin
            if (inf_s) begin
                exp  = {EXP_W{1'b1}};
                mant = {MAN_W{1'b0}};
            end else begin
                exp  = {{(EXP_W-1){1'b1}}, 1'b0};
                mant = {MAN_W{1'b1}};
            end
            inexact = 1'b1;
        end else begin
            exp     = e_s[EXP_W-1:0];
            mant    = mant_sum_s[MAN_W-1:0];
            inexact = guard_s | sticky_s;
        end
        ovf = ovf_s;
    end

endmodule

// File: rtl/int2flt_seq.sv
// Multi-cycle integer-to-float converter with valid/ready handshake.
// Normalizes one bit per cycle, then rounds in a single cycle.
module int2flt_seq
    import int2flt_pkg::*;
#(
    parameter int INT_W       = 16,
    parameter int EXP_W       = 5,
    parameter int MAN_W       = 10,
    parameter int SIGNED_MODE = 0
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INT_W-1:0]       int_in,
    input  logic [1:0]             rnd_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   flt_out,
    output logic                   inexact,
    output logic                   ovf
);

    localparam int MAG_W = INT_W;
    localparam int LZ_W  = $clog2(INT_W);
    localparam logic [MAG_W-1:0] MAG_ONE = {{(MAG_W-1){1'b0}}, 1'b1};
    localparam logic [LZ_W-1:0]  LZ_ONE  = {{(LZ_W-1){1'b0}}, 1'b1};

    state_t                 state_r;
    logic [MAG_W-1:0]       mag_r;
    logic [LZ_W-1:0]        lz_r;
    logic                   sign_r;
    rnd_mode_t              mode_r;
    logic                   out_valid_r;
    logic [EXP_W+MAN_W:0]   flt_r;
    logic                   inexact_r;
    logic                   ovf_r;

    logic                   sign_in_s;
    logic [MAG_W-1:0]       mag_in_s;
    logic                   in_ready_s;
    logic                   accept_s;

    logic [EXP_W-1:0]       rnd_exp_s;
    logic [MAN_W-1:0]       rnd_mant_s;
    logic                   rnd_inexact_s;
    logic                   rnd_ovf_s;

    // Split the operand into sign and unsigned magnitude for the selected encoding.
    always_comb begin
        sign_in_s = int_in[INT_W-1];
        if (SIGNED_MODE != 0) begin
            if (sign_in_s) begin
                mag_in_s = ~int_in + MAG_ONE;
            end else begin
                mag_in_s = int_in;
            end
        end else begin
            mag_in_s = {1'b0, int_in[INT_W-2:0]};
        end
    end

    // Ready in IDLE, or in DONE when the held result is being taken this cycle.
    always_comb begin
        case (state_r)
            IDLE:    in_ready_s = 1'b1;
            DONE:    in_ready_s = out_valid_r & out_ready;
            default: in_ready_s = 1'b0;
        endcase
    end

    assign accept_s  = in_valid & in_ready_s;
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign flt_out   = flt_r;
    assign inexact   = inexact_r;
    assign ovf       = ovf_r;

    flt_round #(
        .MAG_W (MAG_W),
        .LZ_W  (LZ_W),
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .frac    (mag_r[MAG_W-2:0]),
        .lz      (lz_r),
        .sign    (sign_r),
        .mode    (mode_r),
        .exp     (rnd_exp_s),
        .mant    (rnd_mant_s),
        .inexact (rnd_inexact_s),
        .ovf     (rnd_ovf_s)
    );

    // Control FSM with registered result and flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            mag_r       <= {MAG_W{1'b0}};
            lz_r        <= {LZ_W{1'b0}};
            sign_r      <= 1'b0;
            mode_r      <= RNE;
            out_valid_r <= 1'b0;
            flt_r       <= {(EXP_W+MAN_W+1){1'b0}};
            inexact_r   <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (accept_s) begin
            // New operand, either from IDLE or back-to-back out of DONE.
            mag_r       <= mag_in_s;
            lz_r        <= {LZ_W{1'b0}};
            sign_r      <= sign_in_s;
            mode_r      <= rnd_mode_t'(rnd_mode);
            out_valid_r <= 1'b0;
            if (mag_in_s == {MAG_W{1'b0}}) begin
                // Zero skips normalization; result is ready one edge later.
                state_r   <= DONE;
                flt_r     <= {sign_in_s, {(EXP_W+MAN_W){1'b0}}};
                inexact_r <= 1'b0;
                ovf_r     <= 1'b0;
            end else begin
                state_r   <= NORM;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                NORM: begin
                    if (!mag_r[MAG_W-1]) begin
                        mag_r <= {mag_r[MAG_W-2:0], 1'b0};
                        lz_r  <= lz_r + LZ_ONE;
                    end else begin
                        state_r <= ROUND;
                    end
                end
                ROUND: begin
                    flt_r       <= {sign_r, rnd_exp_s, rnd_mant_s};
                    inexact_r   <= rnd_inexact_s;
                    ovf_r       <= rnd_ovf_s;
                    out_valid_r <= 1'b1;
                    state_r     <= DONE;
                end
                DONE: begin
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
